oam_dma_ctrl: RTL and testbench

OAM DMA engine and bus master for the MMU's DMA request port. A CPU write to register 0xFF46 (reached via the MMU's mmio_dma_if) starts a copy of 160 bytes from {src_hi, 8'h00} to OAM at 0xFE00–0xFE9F. The block sequences read and write bus cycles on the DMA port. While idle it parks the DMA address at 0xFFFF; the MMU treats this as "no transfer in progress" and only then grants the CPU access to OAM.

---
 rtl/oam_dma_pkg.sv | 25 ++
 rtl/dma_slot_timer.sv | 28 ++
 rtl/oam_dma_ctrl.sv | 156 +++++++++++++++
 tb/tb_oam_dma_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA engine.
// The source-page fold helper is kept here so the controller and any future users agree on echo mapping.
package oam_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      READ,
      WRITE,
      PAD
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
   localparam logic [15:0] OAM_BASE      = 16'hFE00;
   localparam int          OAM_LEN       = 160;
   localparam logic [15:0] DMA_IDLE_ADDR = 16'hFFFF;
   localparam logic [7:0]  ECHO_FOLD_HI  = 8'hDF;
   localparam logic [7:0]  LAST_IDX      = 8'(OAM_LEN - 1);

   // Pages 0xE0-0xFF are echo RAM; fold them back onto WRAM.
   function automatic logic [7:0] fold_src_hi(input logic [7:0] hi);
      return (hi > ECHO_FOLD_HI) ? hi - 8'h20 : hi;
   endfunction

endpackage

// File: rtl/dma_slot_timer.sv
// Slot timer: down-counter reloaded on each state entry; done is high once it reaches zero.
// Latency: a load of N gives done on the (N+1)th clock after the load edge.
// Backpressure: none; the controller decides when to reload.
module dma_slot_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA engine: FF46 write copies 160 bytes from {src_hi,00} into OAM; optional DMG pacing via OAM_DMA_PACED_EN.
// Latency: 1 + 160*(READ_LATENCY+2) clks unpaced, M_CYCLE_CLKS*161 clks paced, strobe edge to idle.
// Backpressure: none; the MMU must accept every DMA cycle, a new FF46 write restarts the copy at once.
module oam_dma_ctrl
   import oam_dma_pkg::*;
#(
   parameter int READ_LATENCY = 1,
   parameter int M_CYCLE_CLKS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] reg_addr,
   input  logic [7:0]  reg_wdata,
   input  logic        reg_we,
   output logic [7:0]  reg_rdata,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_wdata,
   output logic        dma_we,
   input  logic [7:0]  dma_rdata,
   output logic        dma_active
);

`ifdef OAM_DMA_PACED_EN
   localparam int START_CLKS = M_CYCLE_CLKS;
   localparam int PAD_CLKS   = M_CYCLE_CLKS - (READ_LATENCY + 2);
   if (READ_LATENCY + 2 > M_CYCLE_CLKS) begin : g_bad_pacing
      $error("oam_dma_ctrl: READ_LATENCY+2 exceeds M_CYCLE_CLKS");
   end
`else
   localparam int START_CLKS = 1;
   localparam int PAD_CLKS   = 0;
`endif

   if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
      $error("oam_dma_ctrl: READ_LATENCY must be 1 or 2");
   end

   localparam int TMR_W = $clog2(M_CYCLE_CLKS + READ_LATENCY + 1);
   localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_CLKS - 1);
   localparam logic [TMR_W-1:0] READ_LOAD  = TMR_W'(READ_LATENCY);
   localparam logic [TMR_W-1:0] PAD_LOAD   = TMR_W'((PAD_CLKS > 0) ? PAD_CLKS - 1 : 0);

   dma_state_t       state;
   logic [7:0]       src_hi;
   logic [7:0]       idx;
   logic [7:0]       data_q;
   logic             strobe;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_done;

   assign strobe    = reg_we && (reg_addr == DMA_REG_ADDR);
   assign reg_rdata = (reg_addr == DMA_REG_ADDR) ? src_hi : 8'hFF;

   // Timer reload tracks the transitions made in the state register below.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      if (strobe) begin
         tmr_load = 1'b1;
         tmr_val  = START_LOAD;
      end else begin
         case (state)
            START: begin
               tmr_load = tmr_done;
               tmr_val  = READ_LOAD;
            end
            WRITE: begin
               if (PAD_CLKS > 0) begin
                  tmr_load = 1'b1;
                  tmr_val  = PAD_LOAD;
               end else begin
                  tmr_load = (idx != LAST_IDX);
                  tmr_val  = READ_LOAD;
               end
            end
            PAD: begin
               tmr_load = tmr_done && (idx != LAST_IDX);
               tmr_val  = READ_LOAD;
            end
            default: ;
         endcase
      end
   end

   dma_slot_timer #(.W(TMR_W)) u_slot_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         src_hi <= 8'hFF;
         idx    <= 8'd0;
         data_q <= 8'd0;
      end else if (strobe) begin
         src_hi <= reg_wdata;
         idx    <= 8'd0;
         state  <= START;
      end else begin
         case (state)
            START: if (tmr_done) state <= READ;
            READ: begin
               if (tmr_done) begin
                  data_q <= dma_rdata;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               if (PAD_CLKS > 0) begin
                  state <= PAD;
               end else if (idx == LAST_IDX) begin
                  state <= IDLE;
               end else begin
                  idx   <= idx + 8'd1;
                  state <= READ;
               end
            end
            PAD: begin
               if (tmr_done) begin
                  if (idx == LAST_IDX) begin
                     state <= IDLE;
                  end else begin
                     idx   <= idx + 8'd1;
                     state <= READ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      dma_addr  = DMA_IDLE_ADDR;
      dma_wdata = 8'h00;
      dma_we    = 1'b0;
      case (state)
         READ:  dma_addr = {fold_src_hi(src_hi), idx};
         WRITE: begin
            dma_addr  = OAM_BASE + {8'h00, idx};
            dma_wdata = data_q;
            dma_we    = 1'b1;
         end
         PAD:   dma_addr = OAM_BASE + {8'h00, idx};
         default: ;
      endcase
   end

   assign dma_active = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: a byte-addressed memory model feeds dma_rdata and a queue of
// expected OAM writes is filled at each FF46 write and drained by a write monitor.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_PACED_EN
   localparam int START_CLKS = 4;
   localparam int BYTE_CLKS  = 4;
`else
   localparam int START_CLKS = 1;
   localparam int BYTE_CLKS  = 3;
`endif
   localparam int COPY_CLKS = START_CLKS + 160 * BYTE_CLKS;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] reg_addr = 16'h0000;
   logic [7:0]  reg_wdata = 8'h00;
   logic        reg_we = 1'b0;
   logic [7:0]  reg_rdata;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_we;
   logic [7:0]  dma_rdata;
   logic        dma_active;

   oam_dma_ctrl #(.READ_LATENCY(1), .M_CYCLE_CLKS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_we     (reg_we),
      .reg_rdata  (reg_rdata),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_we     (dma_we),
      .dma_rdata  (dma_rdata),
      .dma_active (dma_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] mem [0:65535];
   logic [7:0] rd_q;
   int         tests = 0;
   int         fails = 0;
   int         wcount = 0;
   int         cyc = 0;
   int         s_cyc = 0;
   int         last_wcyc = 0;
   bit         gap_vld = 1'b0;
   logic [7:0] exp_rd_hi = 8'h00;

   // One-clock read latency memory behind the DMA port.
   always @(posedge clk) begin
      rd_q <= mem[dma_addr];
      cyc  <= cyc + 1;
   end
   assign dma_rdata = rd_q;

   function automatic logic [7:0] src_byte(input logic [7:0] hi, input logic [7:0] lo);
      return lo ^ 8'h5A ^ (hi - 8'hC0);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (dma_we === 1'b1) begin
            wr_t e;
            wcount++;
            if (gap_vld) check("we_gap", cyc - last_wcyc, BYTE_CLKS);
            gap_vld   = 1'b1;
            last_wcyc = cyc;
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("wr_addr", dma_addr, e.addr);
               check("wr_data", dma_wdata, e.data);
            end
         end else if (dma_active === 1'b1 && (cyc - s_cyc) >= START_CLKS) begin
            check("addr_locked", dma_addr != 16'hFFFF, 1);
            if (dma_addr[15:8] != 8'hFE) check("rd_hi", dma_addr[15:8], exp_rd_hi);
         end
      end
   end

   // Called just after a negedge; returns 1 ns after the strobe edge.
   task automatic dma_write(input logic [7:0] src);
      logic [7:0] eff;
      wr_t        e;
      eff = (src >= 8'hE0) ? src - 8'h20 : src;
      exp_q.delete();
      for (int i = 0; i < 160; i++) begin
         e.addr = 16'hFE00 + 16'(i);
         e.data = src_byte(eff, 8'(i));
         exp_q.push_back(e);
      end
      exp_rd_hi = eff;
      gap_vld   = 1'b0;
      reg_addr  = 16'hFF46;
      reg_wdata = src;
      reg_we    = 1'b1;
      @(posedge clk);
      #1;
      reg_we    = 1'b0;
      reg_addr  = 16'h0000;
      s_cyc     = cyc;
   endtask

   task automatic wait_writes(input int target, input string tag);
      int n;
      n = 0;
      while (wcount < target && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      check(tag, wcount >= target, 1);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (dma_active && n < 4000);
      #1;
   endtask

   initial begin
      int n;
      int base;

      for (int h = 'hC0; h < 256; h++)
         for (int l = 0; l < 256; l++)
            mem[16'(h * 256 + l)] = src_byte(8'(h), 8'(l));

      reg_addr = 16'hFF46;
      repeat (3) @(negedge clk);
      check("rst_addr", dma_addr, 16'hFFFF);
      check("rst_we", dma_we, 1'b0);
      check("rst_wdata", dma_wdata, 8'h00);
      check("rst_active", dma_active, 1'b0);
      check("rst_rdata", reg_rdata, 8'hFF);
      rst = 1'b1;
      @(negedge clk);
      #1;
      reg_addr = 16'h1234;
      #1;
      check("rdata_other", reg_rdata, 8'hFF);

      // A write to a neighbouring register must not start anything.
      reg_addr  = 16'hFF45;
      reg_wdata = 8'hC0;
      reg_we    = 1'b1;
      @(posedge clk);
      #1;
      reg_we = 1'b0;
      repeat (3) @(negedge clk);
      check("ff45_ignored", dma_active, 1'b0);
      reg_addr = 16'hFF46;
      #1;
      check("ff45_src", reg_rdata, 8'hFF);
      @(negedge clk);
      #1;

      // Basic unpaced/paced copy from C000.
      base = wcount;
      dma_write(8'hC0);
      wait_idle(n);
      check("copy_clks", n, COPY_CLKS);
      check("copy_writes", wcount - base, 160);
      check("copy_drained", exp_q.size(), 0);
      reg_addr = 16'hFF46;
      #1;
      check("readback_c0", reg_rdata, 8'hC0);

      // Echo page E3 must read from C3xx.
      base = wcount;
      dma_write(8'hE3);
      wait_idle(n);
      check("echo_clks", n, COPY_CLKS);
      check("echo_writes", wcount - base, 160);
      check("echo_drained", exp_q.size(), 0);
      reg_addr = 16'hFF46;
      #1;
      check("readback_e3", reg_rdata, 8'hE3);

      // Restart after 50 bytes with a new source page.
      base = wcount;
      dma_write(8'hC0);
      wait_writes(base + 50, "restart_50");
      dma_write(8'hD0);
      check("restart_start_addr", dma_addr, 16'hFFFF);
      check("restart_active", dma_active, 1'b1);
      wait_idle(n);
      check("restart_clks", n, COPY_CLKS);
      check("restart_writes", wcount - base, 210);
      check("restart_drained", exp_q.size(), 0);

      // Strobe on the edge that ends the final WRITE.
      base = wcount;
      dma_write(8'hC0);
      wait_writes(base + 160, "collide_160");
      check("collide_final_we", dma_we, 1'b1);
      check("collide_final_addr", dma_addr, 16'hFE9F);
      dma_write(8'hD0);
      check("collide_start_addr", dma_addr, 16'hFFFF);
      check("collide_start_we", dma_we, 1'b0);
      check("collide_active", dma_active, 1'b1);
      wait_idle(n);
      check("collide_clks", n, COPY_CLKS);
      check("collide_writes", wcount - base, 320);
      check("collide_drained", exp_q.size(), 0);

      // Asynchronous reset in the middle of a READ.
      dma_write(8'hC0);
      repeat (START_CLKS) @(posedge clk);
      #2;
      check("pre_rst_read_addr", dma_addr, 16'hC000);
      reg_addr = 16'hFF46;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_addr", dma_addr, 16'hFFFF);
      check("midrst_we", dma_we, 1'b0);
      check("midrst_active", dma_active, 1'b0);
      check("midrst_rdata", reg_rdata, 8'hFF);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_idle", dma_active, 1'b0);
      check("post_rst_addr", dma_addr, 16'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
